// File: rtl/ring_rand_param.sv
// Parametrised ring buffer: cyclic prefetched stream plus an independent random-read port over one dual-port RAM.
// Optional macro RING_INDEX_EN adds the 'index' output (RAM address of the word on dout).
module ring_rand_param #(
    parameter int DATA_W   = 4,
    parameter int ADDR_W   = 7,
    parameter int RD_LAT   = 2,  // 1 or 2
    parameter int PF_DEPTH = 3   // >= 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic [DATA_W-1:0] din,
    input  logic              wr_en,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic [DATA_W-1:0] dout,
    output logic              ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rand_rd_addr,
    input  logic              rand_rd_en,
    output logic              rand_rd_ready,
    output logic              rand_rd_valid,
    output logic [DATA_W-1:0] rand_dout
`ifdef RING_INDEX_EN
    ,
    output logic [ADDR_W-1:0] index
`endif
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CW    = $clog2(PF_DEPTH + 1) + 1;

    logic [DATA_W-1:0] mem    [DEPTH];
    logic [DATA_W-1:0] pipe_d [RD_LAT];
    logic [DATA_W-1:0] q      [PF_DEPTH];
    logic [DATA_W-1:0] q_shift[PF_DEPTH];

    logic [ADDR_W:0]   count_r;
    logic [ADDR_W-1:0] rd_ptr, ptr_next, raddr;
    logic [RD_LAT-1:0] str_v, rnd_v;
    logic [CW-1:0]     occ, used, slot;
    logic              rand_busy;
    logic              wr_acc, flush, pop, push, rand_fire, str_issue;

    assign count  = count_r;
    assign full   = (count_r == (ADDR_W+1)'(DEPTH));
    assign wr_acc = wr_en & ~full & ~clr;
    assign flush  = clr | wr_acc;

    assign ready = (occ != '0);
    assign dout  = ready ? q[0] : '0;
    assign pop   = rd_en & ready & ~flush;
    assign slot  = occ - CW'(pop);
    assign push  = str_v[RD_LAT-1] & ~flush;

    assign rand_rd_ready = ~rand_busy;
    assign rand_fire     = rand_rd_en & ~rand_busy;

    // Credit check counts the slot freed by a same-cycle pop so a full queue streams 1 word/cycle.
    assign used      = occ + CW'($countones(str_v)) - CW'(pop);
    assign str_issue = ~rand_fire & ~flush & (count_r != '0) & (used < CW'(PF_DEPTH));
    assign raddr     = rand_fire ? rand_rd_addr : rd_ptr;
    assign ptr_next  = ({1'b0, rd_ptr} == count_r - (ADDR_W+1)'(1)) ? '0 : rd_ptr + ADDR_W'(1);

    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        for (int i = 0; i < PF_DEPTH; i++) q_shift[i] = q[i];
        for (int i = 0; i < PF_DEPTH - 1; i++) q_shift[i] = q[i+1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r       <= '0;
            rd_ptr        <= '0;
            occ           <= '0;
            str_v         <= '0;
            rnd_v         <= '0;
            rand_busy     <= 1'b0;
            rand_rd_valid <= 1'b0;
            rand_dout     <= '0;
        end else begin
            if (clr)         count_r <= '0;
            else if (wr_acc) count_r <= count_r + (ADDR_W+1)'(1);

            if (flush)          rd_ptr <= '0;
            else if (str_issue) rd_ptr <= ptr_next;

            if (flush) occ <= '0;
            else       occ <= slot + CW'(push);

            // Flush drops in-flight stream reads; random reads always complete.
            str_v[0] <= str_issue;
            rnd_v[0] <= rand_fire;
            for (int i = 1; i < RD_LAT; i++) begin
                str_v[i] <= str_v[i-1] & ~flush;
                rnd_v[i] <= rnd_v[i-1];
            end

            if (rand_fire)              rand_busy <= 1'b1;
            else if (rnd_v[RD_LAT-1])   rand_busy <= 1'b0;
            rand_rd_valid <= rnd_v[RD_LAT-1];
            if (rnd_v[RD_LAT-1]) rand_dout <= pipe_d[RD_LAT-1];
        end
    end

    // NOTE: RAM, read pipeline data and queue slots carry no reset; the reset flags above qualify them.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[count_r[ADDR_W-1:0]] <= din;
        pipe_d[0] <= mem[raddr];
        for (int i = 1; i < RD_LAT; i++) pipe_d[i] <= pipe_d[i-1];
        for (int i = 0; i < PF_DEPTH; i++) begin
            if (push && slot == CW'(i)) q[i] <= pipe_d[RD_LAT-1];
            else if (pop)               q[i] <= q_shift[i];
        end
    end

`ifdef RING_INDEX_EN
    logic [ADDR_W-1:0] head_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     head_idx <= '0;
        else if (flush) head_idx <= '0;
        else if (pop)   head_idx <= ({1'b0, head_idx} == count_r - (ADDR_W+1)'(1)) ? '0
                                                                           : head_idx + ADDR_W'(1);
    end

    assign index = ready ? head_idx : '0;
`endif

endmodule

// File: tb/tb_ring_rand_param.sv
// Self-checking bench for ring_rand_param: directed steps plus randomized traffic against an array/pointer model.
module tb_ring_rand_param;

    localparam int DATA_W   = 4;
    localparam int ADDR_W   = 7;
    localparam int RD_LAT   = 2;
    localparam int PF_DEPTH = 3;
    localparam int DEPTH    = 128;

    logic              clk, rst_n, clr, wr_en, rd_en, rand_rd_en;
    logic [DATA_W-1:0] din;
    logic [ADDR_W-1:0] rand_rd_addr;
    logic              full, ready, rand_rd_ready, rand_rd_valid;
    logic [ADDR_W:0]   count;
    logic [DATA_W-1:0] dout, rand_dout;
`ifdef RING_INDEX_EN
    logic [ADDR_W-1:0] index;
`endif

    ring_rand_param #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .PF_DEPTH(PF_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .din(din), .wr_en(wr_en),
        .full(full), .count(count), .dout(dout), .ready(ready), .rd_en(rd_en),
        .rand_rd_addr(rand_rd_addr), .rand_rd_en(rand_rd_en),
        .rand_rd_ready(rand_rd_ready), .rand_rd_valid(rand_rd_valid), .rand_dout(rand_dout)
`ifdef RING_INDEX_EN
        , .index(index)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: stored words, word count, address of the stream head, one pending random read.
    int mem_m [DEPTH];
    bit mem_known [DEPTH];
    int count_m, ptr_m, cyc, pops;
    bit rnd_pend, rnd_known;
    int rnd_exp, rnd_due;
    int checks, errors;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe pre-edge state, advance the model on the edge, check post-edge outputs.
    task automatic tick();
        bit pre_ready, flush_m, pop_m;
        pre_ready = ready;
        if (pre_ready) check("head_data", dout, mem_m[ptr_m]);
`ifdef RING_INDEX_EN
        check("index", index, pre_ready ? ptr_m : 0);
`endif
        if (rand_rd_en) begin
            check("rand_ready", rand_rd_ready, !rnd_pend);
            if (!rnd_pend) begin
                rnd_pend  = 1;
                rnd_known = mem_known[rand_rd_addr];
                rnd_exp   = mem_m[rand_rd_addr];
                rnd_due   = cyc + 1 + RD_LAT;
            end
        end
        flush_m = clr || (wr_en && count_m < DEPTH);
        pop_m   = rd_en && pre_ready && !flush_m;
        @(posedge clk);
        cyc++;
        if (clr) begin
            count_m = 0;
            ptr_m   = 0;
        end else if (wr_en && count_m < DEPTH) begin
            mem_m[count_m]     = din;
            mem_known[count_m] = 1;
            count_m++;
            ptr_m = 0;
        end else if (pop_m && count_m != 0) begin
            ptr_m = (ptr_m + 1) % count_m;
            pops++;
        end
        #1;
        check("count", count, count_m);
        check("full", full, count_m == DEPTH);
        if (rnd_pend && cyc == rnd_due) begin
            check("rand_valid", rand_rd_valid, 1);
            if (rnd_known) check("rand_dout", rand_dout, rnd_exp);
            rnd_pend = 0;
        end else begin
            check("rand_valid_idle", rand_rd_valid, 0);
        end
        if (count_m == 0) check("ready_empty", ready, 0);
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 20 && !ready; i++) tick();
        check(tag, ready, 1);
    endtask

    initial begin
        int p0;
        checks = 0; errors = 0; cyc = 0; pops = 0;
        count_m = 0; ptr_m = 0; rnd_pend = 0;
        rst_n = 0; clr = 0; wr_en = 0; rd_en = 0; rand_rd_en = 0; din = '0; rand_rd_addr = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_ready", ready, 0);
        check("rst_dout", dout, 0);
        check("rst_rand_valid", rand_rd_valid, 0);
        check("rst_rand_dout", rand_dout, 0);
        check("rst_rand_ready", rand_rd_ready, 1);
`ifdef RING_INDEX_EN
        check("rst_index", index, 0);
`endif
        rst_n = 1;
        tick();

        // Write 5,6,7; ready exactly 3 cycles after the last write; 7 back-to-back pops
        wr_en = 1;
        din = 4'd5; tick();
        din = 4'd6; tick();
        din = 4'd7; tick();
        wr_en = 0;
        tick(); check("fill_k1", ready, 0);
        tick(); check("fill_k2", ready, 0);
        tick(); check("fill_k3", ready, 1);
        check("first_word", dout, 5);
        rd_en = 1;
        p0 = pops;
        repeat (7) tick();
        check("pop_rate7", pops - p0, 7);
        check("after7_head", dout, 6);

        // Random read of addr 1 during continuous popping
        rand_rd_en = 1; rand_rd_addr = 7'd1; tick();
        rand_rd_en = 0;
        check("rand_busy", rand_rd_ready, 0);
        tick();
        check("rand_early", rand_rd_valid, 0);
        tick();
        check("rand_pulse", rand_rd_valid, 1);
        check("rand_addr1", rand_dout, 6);
        repeat (10) tick();
        rd_en = 0;

        // clr, then same-cycle write of 9 and random read of addr 0: old data returned
        clr = 1; tick(); clr = 0;
        check("clr_ready", ready, 0);
        wr_en = 1; din = 4'd9; rand_rd_en = 1; rand_rd_addr = 7'd0; tick();
        wr_en = 0; rand_rd_en = 0;
        tick();
        tick();
        check("rw_old_data", rand_dout, 5);
        tick();
        check("fill_after_collision", ready, 1);
        check("new_word9", dout, 9);
        tick();

        // Random read during fill delays ready by exactly one cycle
        wr_en = 1; din = 4'd3; tick();
        wr_en = 0; rand_rd_en = 1; rand_rd_addr = 7'd1; tick();
        rand_rd_en = 0;
        tick(); check("fill_rand_k2", ready, 0);
        tick(); check("fill_rand_k3", ready, 0);
        tick(); check("fill_rand_k4", ready, 1);
        check("rand_fill_data", rand_dout, 3);

        // Fill all 128 entries, 129th write ignored, stream wraps 127 -> 0
        clr = 1; tick(); clr = 0;
        wr_en = 1;
        for (int i = 0; i < DEPTH; i++) begin
            din = DATA_W'($urandom_range(0, 15));
            tick();
        end
        wr_en = 0;
        check("full_set", full, 1);
        wait_ready("fill_128");
        tick();
        wr_en = 1; din = ~DATA_W'(mem_m[0]); tick();
        wr_en = 0;
        check("full_write_ignored_count", count, DEPTH);
        check("full_write_no_flush", ready, 1);
        rd_en = 1;
        p0 = pops;
        repeat (135) tick();
        check("wrap_rate", pops - p0, 135);
        rd_en = 0;

        // Randomized traffic: writes, clears, pops, random reads (incl. addresses >= count)
        for (int n = 0; n < 400; n++) begin
            int r;
            r            = int'($urandom_range(0, 99));
            clr          = (r < 2);
            wr_en        = (r >= 2 && r < 9);
            din          = DATA_W'($urandom_range(0, 15));
            rd_en        = ($urandom_range(0, 99) < 70);
            rand_rd_en   = ($urandom_range(0, 3) == 0);
            rand_rd_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
            tick();
        end
        clr = 0; wr_en = 0; rd_en = 0; rand_rd_en = 0;
        repeat (4) tick();

`ifdef RING_INDEX_EN
        // index follows 0,1,2,0 across pops; clr returns it to 0
        clr = 1; tick(); clr = 0;
        wr_en = 1;
        for (int i = 0; i < 3; i++) begin
            din = DATA_W'(i + 1);
            tick();
        end
        wr_en = 0;
        wait_ready("idx_fill");
        check("idx_0", index, 0);
        rd_en = 1;
        tick(); check("idx_1", index, 1);
        tick(); check("idx_2", index, 2);
        tick(); check("idx_wrap", index, 0);
        rd_en = 0;
        clr = 1; tick(); clr = 0;
        check("idx_clr_ready", ready, 0);
        check("idx_clr", index, 0);
`endif

        // Asynchronous reset while a random read is pending
        wr_en = 1; din = 4'd4; tick(); wr_en = 0;
        rand_rd_en = 1; rand_rd_addr = 7'd0; tick();
        rand_rd_en = 0;
        rst_n = 0;
        #1;
        check("arst_count", count, 0);
        check("arst_ready", ready, 0);
        check("arst_rand_valid", rand_rd_valid, 0);
        check("arst_rand_ready", rand_rd_ready, 1);
        check("arst_rand_dout", rand_dout, 0);
        count_m = 0; ptr_m = 0; rnd_pend = 0;
        @(negedge clk);
        rst_n = 1;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
